// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size encodings, the FSM state type and the byte-address to word-index mapping.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    DONE
  } state_e;

  // Word index of a byte address, keeping only the bits that address the memory.
  // Requests beyond the memory are rejected before this is used when the
  // alignment check is built in, so the mask never hides a real address there.
  function automatic logic [31:0] wordIndex(input logic [31:0] byteAddr,
                                            input logic [31:0] depthWords);
    return {2'b00, byteAddr[31:2]} & (depthWords - 32'd1);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Lane handling for the load/store unit (purely combinational).
// Builds the read-modify-write word for byte/half stores and extracts and
// extends the addressed lane for loads. Lanes are little-endian; halves use
// only byteOff_i[1], so an odd half address is aligned down.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] oldWord_i,
  input  logic [31:0] storeData_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  byteOff_i,
  input  logic        isUnsigned_i,
  output logic [31:0] mergedWord_o,
  output logic [31:0] loadValue_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Replace or extract the addressed lane; word (and reserved) sizes pass through whole
  always_comb begin
    mergedWord_o = storeData_i;
    loadValue_o  = oldWord_i;
    laneByte     = oldWord_i[{byteOff_i, 3'b000} +: 8];
    laneHalf     = oldWord_i[{byteOff_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_B: begin
        mergedWord_o = oldWord_i;
        mergedWord_o[{byteOff_i, 3'b000} +: 8] = storeData_i[7:0];
        loadValue_o = isUnsigned_i ? {24'h000000, laneByte}
                                   : {{24{laneByte[7]}}, laneByte};
      end
      SZ_H: begin
        mergedWord_o = oldWord_i;
        mergedWord_o[{byteOff_i[1], 4'b0000} +: 16] = storeData_i[15:0];
        loadValue_o = isUnsigned_i ? {16'h0000, laneHalf}
                                   : {{16{laneHalf[15]}}, laneHalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for the word-wide data memory.
// One request at a time: loads go RD->MRG->DONE, word stores WR->DONE,
// byte/half stores RD->MRG->WR->DONE (read-modify-write).
// Optional build macro LSU_ALIGN_CHECK_EN: reject misaligned, reserved-size and
// out-of-range requests with resp_err instead of aligning/masking them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_w_data,
  input  logic [31:0] m_r_data
);

  state_e      state_q, state_d;
  logic        reqWe_q, reqUnsigned_q;
  logic [1:0]  reqSize_q, byteOff_q;
  logic [31:0] reqWdata_q, mAddr_q, mWData_q, respRdata_q;
  logic        accept, reqErr, isWordStore;
  logic [31:0] mergedWord, loadValue;

  assign req_ready   = (state_q == IDLE) && rst;
  assign accept      = req_valid && req_ready;
  assign isWordStore = req_we && ((req_size == SZ_W) || (req_size == SZ_RSV));
  assign resp_valid  = (state_q == DONE) && rst;
  assign mem_write   = (state_q == WR) && rst;
  assign m_addr      = mAddr_q;
  assign m_w_data    = mWData_q;
  assign resp_rdata  = respRdata_q;

`ifdef LSU_ALIGN_CHECK_EN
  logic errQ;

  // Classify the incoming request as misaligned, reserved-size or out of range
  always_comb begin
    reqErr = 1'b0;
    case (req_size)
      SZ_B:    reqErr = 1'b0;
      SZ_H:    reqErr = req_addr[0];
      SZ_W:    reqErr = (req_addr[1:0] != 2'b00);
      default: reqErr = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH_WORDS) reqErr = 1'b1;
  end

  // Remember whether the accepted request was rejected, for the DONE pulse
  always_ff @(posedge clk) begin
    if (!rst) errQ <= 1'b0;
    else if (accept) errQ <= reqErr;
  end

  assign resp_err = resp_valid && errQ;
`else
  assign reqErr   = 1'b0;
  assign resp_err = 1'b0;
`endif

  lsu_lane_merge u_lane_merge (
    .oldWord_i    (m_r_data),
    .storeData_i  (reqWdata_q),
    .size_i       (reqSize_q),
    .byteOff_i    (byteOff_q),
    .isUnsigned_i (reqUnsigned_q),
    .mergedWord_o (mergedWord),
    .loadValue_o  (loadValue)
  );

  // State register; a low rst drops any request in flight
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state selection for the load, word-store and read-modify-write paths
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reqErr)           state_d = DONE;
          else if (isWordStore) state_d = WR;
          else                  state_d = RD;
        end
      end
      RD:      state_d = MRG;
      MRG:     state_d = reqWe_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request at accept and capture merged/load data at the end of MRG
  always_ff @(posedge clk) begin
    if (!rst) begin
      reqWe_q       <= 1'b0;
      reqUnsigned_q <= 1'b0;
      reqSize_q     <= 2'b00;
      byteOff_q     <= 2'b00;
      reqWdata_q    <= 32'h0;
      mAddr_q       <= 32'h0;
      mWData_q      <= 32'h0;
      respRdata_q   <= 32'h0;
    end else begin
      if (accept) begin
        reqWe_q       <= req_we;
        reqUnsigned_q <= req_unsigned;
        reqSize_q     <= req_size;
        byteOff_q     <= req_addr[1:0];
        reqWdata_q    <= req_wdata;
        if (!reqErr) begin
          mAddr_q <= wordIndex(req_addr, DEPTH_WORDS);
          if (isWordStore) mWData_q <= req_wdata;
        end
      end
      if (state_q == MRG) begin
        if (reqWe_q) mWData_q    <= mergedWord;
        else         respRdata_q <= loadValue;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory.
// Expected responses are queued when a request is accepted and compared
// when resp_valid pulses.
module tb_load_store_unit;

  localparam int DEPTH = 128;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_write;
  logic [31:0] resp_rdata, m_addr, m_w_data, m_r_data;

  logic [31:0] mem [DEPTH];
  int          cycleCnt = 0;
  int          memWrites = 0;
  int          errors = 0;
  int          checks = 0;
  int          lastAcceptCnt = 0;
  int          lastLat = 0;
  logic        prevResp = 1'b0;
  int          memWritesBefore;

  typedef struct packed {
    logic [31:0] rdata;
    logic        checkData;
    logic        err;
    logic [31:0] latency;
    logic [31:0] acceptCnt;
  } sb_t;

  sb_t   sbQ[$];
  string tagQ[$];
  sb_t   popped;
  string poppedTag;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_write    (mem_write),
    .m_addr       (m_addr),
    .m_w_data     (m_w_data),
    .m_r_data     (m_r_data)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure accept-to-response latency
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Data memory: registered read, write on the falling edge
  always @(posedge clk) m_r_data <= mem[m_addr[6:0]];
  always @(negedge clk) begin
    if (mem_write) begin
      mem[m_addr[6:0]] <= m_w_data;
      memWrites++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Scoreboard consumer: every resp_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (prevResp) checkOutput("pulse_width", {31'b0, resp_valid}, 32'd0);
    prevResp = resp_valid;
    if (resp_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      end else begin
        popped    = sbQ.pop_front();
        poppedTag = tagQ.pop_front();
        checkOutput({poppedTag, "_err"}, {31'b0, resp_err}, {31'b0, popped.err});
        checkOutput({poppedTag, "_lat"}, 32'(cycleCnt) - popped.acceptCnt, popped.latency);
        checkOutput({poppedTag, "_ready"}, {31'b0, req_ready}, 32'd0);
        if (popped.checkData) checkOutput({poppedTag, "_rdata"}, resp_rdata, popped.rdata);
      end
    end
  end

  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic expectResp,
                               input logic [31:0] expRdata, input logic expErr,
                               input logic keepValid, input logic checkGap);
    int   tries;
    int   lat;
    sb_t  e;
    tries = 0;
    do begin
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      tries++;
    end while (!req_ready && tries < 50);
    if (!req_ready) begin
      checkOutput({tag, "_accept_timeout"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (expErr)                       lat = 1;
    else if (we && (size == W || size == R)) lat = 2;
    else if (we)                      lat = 4;
    else                              lat = 3;
    if (checkGap) checkOutput({tag, "_gap"}, 32'(cycleCnt - lastAcceptCnt), 32'(lastLat + 1));
    lastAcceptCnt = cycleCnt;
    lastLat       = lat;
    if (expectResp) begin
      e.rdata     = expRdata;
      e.checkData = !we;
      e.err       = expErr;
      e.latency   = 32'(lat);
      e.acceptCnt = 32'(cycleCnt);
      sbQ.push_back(e);
      tagQ.push_back(tag);
    end
    @(posedge clk);
    #1;
    if (!keepValid) req_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
      tagQ.delete();
    end
    @(negedge clk);
  endtask

  // Watchdog so a stuck design still terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = B;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready",  {31'b0, req_ready},  32'd0);
    checkOutput("rst_resp",   {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_rdata",  resp_rdata,          32'd0);
    checkOutput("rst_err",    {31'b0, resp_err},   32'd0);
    checkOutput("rst_mwrite", {31'b0, mem_write},  32'd0);
    checkOutput("rst_maddr",  m_addr,              32'd0);
    checkOutput("rst_mwdata", m_w_data,            32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Word store then word load
    applyStimulus("st_w_10", 1, W, 0, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    waitDrain(20);
    checkOutput("st_w_10_maddr", m_addr, 32'd4);
    checkOutput("st_w_10_mem", mem[4], 32'hDEADBEEF);
    applyStimulus("ld_w_10", 0, W, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 0, 0);
    waitDrain(20);
    checkOutput("ld_w_10_maddr", m_addr, 32'd4);

    // Byte store over a cleared word, signed/unsigned byte loads
    applyStimulus("clr_w_10", 1, W, 0, 32'h10, 32'h0, 1, 0, 0, 0, 0);
    applyStimulus("st_b_13", 1, B, 0, 32'h13, 32'h0000007F, 1, 0, 0, 0, 0);
    waitDrain(20);
    checkOutput("st_b_13_mem", mem[4], 32'h7F000000);
    applyStimulus("ld_b_13", 0, B, 0, 32'h13, 32'h0, 1, 32'h0000007F, 0, 0, 0);
    applyStimulus("st_b_11", 1, B, 0, 32'h11, 32'hFFFFFF80, 1, 0, 0, 0, 0);
    applyStimulus("ld_bs_11", 0, B, 0, 32'h11, 32'h0, 1, 32'hFFFFFF80, 0, 0, 0);
    applyStimulus("ld_bu_11", 0, B, 1, 32'h11, 32'h0, 1, 32'h00000080, 0, 0, 0);
    waitDrain(20);
    checkOutput("st_b_11_mem", mem[4], 32'h7F008000);

    // Half store into the upper half, lower half must survive
    applyStimulus("st_w_20", 1, W, 0, 32'h20, 32'h1234ABCD, 1, 0, 0, 0, 0);
    applyStimulus("st_h_22", 1, H, 0, 32'h22, 32'h55558001, 1, 0, 0, 0, 0);
    applyStimulus("ld_hs_22", 0, H, 0, 32'h22, 32'h0, 1, 32'hFFFF8001, 0, 0, 0);
    applyStimulus("ld_hu_22", 0, H, 1, 32'h22, 32'h0, 1, 32'h00008001, 0, 0, 0);
    applyStimulus("ld_hu_20", 0, H, 1, 32'h20, 32'h0, 1, 32'h0000ABCD, 0, 0, 0);
    waitDrain(20);
    checkOutput("st_h_22_mem", mem[8], 32'h8001ABCD);

    // Misaligned and out-of-range requests
    applyStimulus("st_w_04", 1, W, 0, 32'h04, 32'hCAFEF00D, 1, 0, 0, 0, 0);
    waitDrain(20);
`ifdef LSU_ALIGN_CHECK_EN
    memWritesBefore = memWrites;
    applyStimulus("ld_w_06_err", 0, W, 0, 32'h06, 32'h0, 1, 32'h0000ABCD, 1, 0, 0);
    applyStimulus("ld_w_200_err", 0, W, 0, 32'h200, 32'h0, 1, 32'h0000ABCD, 1, 0, 0);
    applyStimulus("ld_r_04_err", 0, R, 0, 32'h04, 32'h0, 1, 32'h0000ABCD, 1, 0, 0);
    applyStimulus("st_h_21_err", 1, H, 0, 32'h21, 32'h0, 1, 0, 1, 0, 0);
    waitDrain(20);
    checkOutput("err_no_mem_write", 32'(memWrites - memWritesBefore), 32'd0);
`else
    applyStimulus("ld_w_06", 0, W, 0, 32'h06, 32'h0, 1, 32'hCAFEF00D, 0, 0, 0);
    waitDrain(20);
    checkOutput("ld_w_06_maddr", m_addr, 32'd1);
    applyStimulus("ld_r_04", 0, R, 0, 32'h04, 32'h0, 1, 32'hCAFEF00D, 0, 0, 0);
    applyStimulus("ld_w_200", 0, W, 0, 32'h200, 32'h0, 1, 32'h00000000, 0, 0, 0);
    waitDrain(20);
    checkOutput("ld_w_200_maddr", m_addr, 32'd0);
`endif

    // Reset asserted during the WR cycle of a byte store
    applyStimulus("st_b_rst", 1, B, 0, 32'h10, 32'h000000AA, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_wr_mwrite", {31'b0, mem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_mem", mem[4], 32'h7F008000);
    checkOutput("rst_wr_maddr", m_addr, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_wr_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);

    // req_valid held high across consecutive requests
    applyStimulus("bb_st_w", 1, W, 0, 32'h40, 32'h11111111, 1, 0, 0, 1, 0);
    applyStimulus("bb_ld_w", 0, W, 0, 32'h40, 32'h0, 1, 32'h11111111, 0, 1, 1);
    applyStimulus("bb_st_b", 1, B, 0, 32'h41, 32'h00000022, 1, 0, 0, 1, 1);
    applyStimulus("bb_ld_bu", 0, B, 1, 32'h41, 32'h0, 1, 32'h00000022, 0, 0, 1);
    waitDrain(30);
    checkOutput("bb_mem", mem[16], 32'h11112211);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end for the 128-word data memory. Accepts one CPU request at a time over a valid/ready handshake, converts byte addresses to word indices, and performs byte and halfword stores as read-modify-write sequences. Returns sign- or zero-extended load data and an error flag. Sits between the execute stage and the data memory: it drives the memory's write enable, word address and write data, and consumes its registered read data.

## Interface
- DEPTH_WORDS, 128: memory depth in 32-bit words; power of two.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE with rst high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; holds its value until the next load completes.
- resp_err  out  1  qualifies resp_valid.
- mem_write  out  1  memory write enable; the memory writes on the falling edge.
- m_addr  out  32  word index: {2'b0, addr[31:2]}.
- m_w_data  out  32  full-word write data.
- m_r_data  in  32  memory read data, valid the cycle after m_addr is presented.

## Operation
- FSM states: IDLE, RD, MRG, WR, DONE.
- Accept: req_valid && req_ready at a rising edge. All request fields are latched at that edge and ignored afterwards.
- Load path: IDLE→RD→MRG→DONE.
  - RD drives m_addr.
  - MRG extracts the lane from m_r_data, extends it, and registers it into resp_rdata.
- Word store path: IDLE→WR→DONE.
- Byte/half store path: IDLE→RD→MRG→WR→DONE.
  - MRG registers the merged word: old word with the target lane(s) replaced.
- Lanes are little-endian. Byte k = addr[1:0] occupies bits [8k+7:8k]. A half at addr[1]=h occupies bits [16h+15:16h].
- WR: mem_write = 1 gated by rst; m_w_data = req_wdata for word stores, the merged word otherwise.
- DONE: resp_valid = 1 for one cycle, then IDLE. resp_err is 0 unless flagged by the check in Configuration.
- m_addr holds the latched word index from RD through DONE. It is 0 in IDLE after reset and otherwise holds its last value.

## Timing
- Accept edge = E0. resp_valid is high in the cycle after edge:
  - E2 for word store
  - E3 for load
  - E4 for byte/half store
  - E1 for error
- Next accept is possible at the edge that ends DONE + 1, i.e. first IDLE cycle. No back-to-back acceptance.
- Reset values, applied at any rising edge with rst low:
  - state IDLE
  - req_ready 0 (1 from the first cycle rst is high)
  - resp_valid 0, resp_rdata 0, resp_err 0
  - mem_write 0, m_addr 0, m_w_data 0
- Reset mid-operation: the request is dropped and no resp_valid is issued. If rst is low during a WR cycle, mem_write is forced 0 combinationally and no write occurs.
- resp_valid and req_ready are never high in the same cycle.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - Flags misaligned half (addr[0]=1), misaligned word (addr[1:0]≠0), req_size=11, and out-of-range addresses (addr[31:2] ≥ DEPTH_WORDS).
  - A flagged request goes IDLE→DONE with resp_err=1 and no memory access.
  - resp_rdata is unchanged.
- LSU_ALIGN_CHECK_EN undefined:
  - resp_err is tied 0.
  - req_size=11 is treated as word.
  - Half addresses are aligned down (addr[0] ignored) and word addresses are aligned down (addr[1:0] ignored).
  - m_addr keeps only the low log2(DEPTH_WORDS) index bits; the rest are zero.

## Structure
- Package lsu_pkg:
  - size encodings SZ_B, SZ_H, SZ_W
  - FSM state enum
  - function computing the word index from a byte address
- Sub-module lsu_lane_merge, purely combinational:
  - inputs: old word, store data, size, addr[1:0]
  - outputs: merged word, extracted/extended load value
  - instantiated once in load_store_unit.

## Test plan
- Word store 0xDEADBEEF @0x10, then load word @0x10 → m_addr=4; resp_valid at E2 and E3 respectively; resp_rdata=0xDEADBEEF.
- Byte store 0x7F @0x13 over 0x00000000, then signed byte load @0x13 → memory word 0x7F000000; resp_rdata=0x0000007F.
- Half store 0x8001 @0x22, then signed half load → 0xFFFF8001; unsigned half load → 0x00008001; low half of the word unchanged.
- With macro defined: word load @0x06 and load @0x200 → resp_err=1 at E1; mem_write never asserted. Without macro: @0x06 reads word 1.
- rst low during the WR cycle of a byte store → mem_write=0, target word unchanged, no resp_valid, req_ready=1 after rst returns high.
- req_valid held high continuously → accepts spaced one per transaction; each resp_valid is exactly one cycle wide.
